echo_meter: RTL and testbench
=============================

# echo_meter

Measurement front-end for the HC-SR04 ultrasonic ranger. It fires periodic trigger pulses and times the sensor's returning echo pulse in clock cycles. It reports each result as a width word with a one-cycle valid strobe, or a one-cycle timeout strobe if no echo completes. It sits between the sensor pins and the distance/LED decode stage, which consumes `width`/`valid`.

## Interface
- `TRIG_CYCLES`, 10: trigger high time in clock cycles (≥1).
- `PERIOD_CYCLES`, 60000: cycles between consecutive trigger rising edges. Must exceed `TRIG_CYCLES + TIMEOUT_CYCLES + 4`.
- `TIMEOUT_CYCLES`, 30000: maximum cycles allowed from end of trigger to echo fall (≥2).
- `WIDTH`, 16: width of the measurement result.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `echo` in 1: raw asynchronous echo from the sensor.
- `trig` out 1: registered trigger to the sensor.
- `width` out WIDTH: last echo width in cycles; held until the next result.
- `valid` out 1: one-cycle strobe; `width` holds a new measurement.
- `timeout` out 1: one-cycle strobe; measurement abandoned.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- `echo` passes through a 2-flop synchronizer to give `echo_s`. `echo_s_d` is a further 1-flop delay used for edge detection. Synchronizer flops reset to 0.
- FSM states and transitions:
  - IDLE: `trig` is 0. When the period counter reaches `PERIOD_CYCLES-1`, or on the first edge after reset, go to TRIG and clear the period counter.
  - TRIG: `trig` is 1 for exactly `TRIG_CYCLES` cycles, then go to WAIT_RISE. Clear the timeout counter on entry to WAIT_RISE.
  - WAIT_RISE: wait for a rising edge of `echo_s` (`echo_s`=1 and `echo_s_d`=0). On the rising edge go to MEASURE with count=1. A level already high on entry is ignored; only a 0→1 transition starts a measurement.
  - MEASURE: increment count each cycle `echo_s`=1; count saturates at 2^WIDTH−1 with no wrap. On `echo_s`=0: load `width`←count, pulse `valid`, go to IDLE.
- Timeout counter increments every cycle in WAIT_RISE and MEASURE. When it equals `TIMEOUT_CYCLES-1`:
  - go to IDLE, pulse `timeout`, load `width`←all ones;
  - `valid` is not asserted;
  - timeout takes priority over a simultaneous echo fall.
- Period counter is free-running from each trigger rise and saturates at `PERIOD_CYCLES-1` while waiting in IDLE. The trigger cadence is therefore exact regardless of the measurement outcome.
- `valid` and `timeout` are never high together. Each is high for exactly one cycle per measurement.

## Timing
- Reset values: `trig`=0, `width`=0, `valid`=0, `timeout`=0, `busy`=0; FSM=IDLE; all counters 0.
- Reset mid-operation: all outputs take their reset values on that edge and `trig` drops immediately. No strobe is emitted for the aborted measurement.
- First trigger: `trig`=1 after the first rising edge with `rst`=0. It stays high for `TRIG_CYCLES` edges.
- Latency on a synchronously aligned echo:
  - edge k is the first edge sampling `echo`=1; count starts at edge k+3;
  - edge m is the first edge sampling `echo`=0; `valid` is high after edge m+3 and low after edge m+4;
  - an echo high for N sampled edges reports `width`=N.
- `busy` rises with `trig` and falls on the edge that asserts `valid` or `timeout`.

## Test plan
Bench parameters: `TRIG_CYCLES`=5, `PERIOD_CYCLES`=200, `TIMEOUT_CYCLES`=100, `WIDTH`=8 unless stated.
- Hold `rst` for 4 cycles, then release → all outputs 0 during reset. `trig` is high for exactly 5 cycles starting at the first edge after release. Next `trig` rise is exactly 200 cycles later.
- Echo rises 20 cycles after `trig` falls and stays high 15 edges → `width`=15. `valid` is high for 1 cycle, 3 edges after echo falls; `timeout` stays 0.
- No echo → `timeout` pulses 100 cycles after WAIT_RISE entry. `width`=255, `valid` stays 0, and the next trigger keeps the 200-cycle cadence.
- Echo held high from before the trigger through the window → no `valid`; `timeout` pulses at 100.
- `WIDTH`=6, echo high 80 edges → `width`=63 (saturated), `valid`=1, no wrap to 16.
- Assert `rst` for 1 cycle mid-MEASURE → outputs 0 on that edge. No `valid`/`timeout` for the aborted pulse. A fresh 5-cycle trigger follows the first edge after release.

Source files
------------

// File: rtl/echo_meter.sv
// HC-SR04 measurement front-end: periodic trigger, echo-width timing with
// saturation, timeout handling and one-cycle result strobes.
module echo_meter #(
  parameter int unsigned TRIG_CYCLES    = 10,
  parameter int unsigned PERIOD_CYCLES  = 60000,
  parameter int unsigned TIMEOUT_CYCLES = 30000,
  parameter int unsigned WIDTH          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             echo,
  output logic             trig,
  output logic [WIDTH-1:0] width,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  localparam int unsigned PW = $clog2(PERIOD_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = $clog2(TRIG_CYCLES + 1);

  localparam logic [PW-1:0]    PeriodLast = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0]    ToutLast   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0]    TrigLast   = GW'(TRIG_CYCLES - 1);
  localparam logic [WIDTH-1:0] CountMax   = '1;

  typedef enum logic [1:0] {StIdle, StTrig, StWaitRise, StMeasure} state_e;

  state_e state_q, state_d;

  logic echo_meta, echo_s, echo_s_d, rise_q;

  logic [PW-1:0]    period_q, period_d;
  logic [TW-1:0]    tout_q, tout_d;
  logic [GW-1:0]    trig_cnt_q, trig_cnt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] width_q, width_d;
  logic             started_q, started_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             trig_q;

  // Edge detect is registered, so the FSM sees the level one cycle later too
  // (echo_s_d) to keep the measured width equal to the sampled high time.
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
      echo_s_d  <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
      echo_s_d  <= echo_s;
      rise_q    <= echo_s & ~echo_s_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    period_d   = (period_q == PeriodLast) ? period_q : period_q + PW'(1);
    tout_d     = tout_q;
    trig_cnt_d = trig_cnt_q;
    count_d    = count_q;
    width_d    = width_q;
    started_d  = started_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!started_q || period_q == PeriodLast) begin
          state_d    = StTrig;
          period_d   = '0;
          trig_cnt_d = '0;
          started_d  = 1'b1;
        end
      end
      StTrig: begin
        if (trig_cnt_q == TrigLast) begin
          state_d = StWaitRise;
          tout_d  = '0;
        end else begin
          trig_cnt_d = trig_cnt_q + GW'(1);
        end
      end
      StWaitRise: begin
        tout_d = tout_q + TW'(1);
        if (tout_q == ToutLast) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
          width_d   = '1;
        end else if (rise_q) begin
          state_d = StMeasure;
          count_d = WIDTH'(1);
        end
      end
      StMeasure: begin
        tout_d = tout_q + TW'(1);
        // Timeout wins over a simultaneous echo fall.
        if (tout_q == ToutLast) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
          width_d   = '1;
        end else if (!echo_s_d) begin
          state_d = StIdle;
          valid_d = 1'b1;
          width_d = count_q;
        end else if (count_q != CountMax) begin
          count_d = count_q + WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      period_q   <= '0;
      tout_q     <= '0;
      trig_cnt_q <= '0;
      count_q    <= '0;
      width_q    <= '0;
      started_q  <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      trig_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      tout_q     <= tout_d;
      trig_cnt_q <= trig_cnt_d;
      count_q    <= count_d;
      width_q    <= width_d;
      started_q  <= started_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      trig_q     <= (state_d == StTrig);
    end
  end

  assign trig    = trig_q;
  assign width   = width_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_echo_meter.sv
// Directed bench for echo_meter: an 8-bit instance for cadence, measurement,
// timeout and reset cases, and a 6-bit instance for saturation.
module tb_echo_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       echo = 1'b0;
  logic       echo6 = 1'b0;
  logic       trig, valid, timeout, busy;
  logic [7:0] width;
  logic       trig6, valid6, timeout6, busy6;
  logic [5:0] width6;

  int n_cmp = 0;
  int n_err = 0;
  int v_cnt = 0;
  int t_cnt = 0;

  always #5 clk = ~clk;

  echo_meter #(
    .TRIG_CYCLES(5), .PERIOD_CYCLES(200), .TIMEOUT_CYCLES(100), .WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .echo(echo), .trig(trig), .width(width),
    .valid(valid), .timeout(timeout), .busy(busy)
  );

  echo_meter #(
    .TRIG_CYCLES(5), .PERIOD_CYCLES(200), .TIMEOUT_CYCLES(100), .WIDTH(6)
  ) dut6 (
    .clk(clk), .rst(rst), .echo(echo6), .trig(trig6), .width(width6),
    .valid(valid6), .timeout(timeout6), .busy(busy6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held for 4 edges
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("rst_trig", 32'(trig), 0);
    chk("rst_width", 32'(width), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_width6", 32'(width6), 0);
    rst = 1'b0;

    // Edge e = e-th rising edge after reset release
    for (int e = 1; e <= 760; e++) begin
      @(posedge clk);
      #1;
      if (valid) v_cnt++;
      if (timeout) t_cnt++;

      // First trigger: edges 1..5 high, low from 6
      if (e >= 1 && e <= 5) chk($sformatf("trig1_e%0d", e), 32'(trig), 1);
      if (e == 1) chk("busy_first", 32'(busy), 1);
      if (e == 6) begin
        chk("trig1_fall", 32'(trig), 0);
        chk("busy_wait", 32'(busy), 1);
      end

      // Echo sampled high at edges 26..40 (m=41): valid at 44, width 15
      if (e == 43) chk("valid_early", 32'(valid), 0);
      if (e == 44) begin
        chk("valid_pulse", 32'(valid), 1);
        chk("width15", 32'(width), 15);
        chk("no_timeout_meas", 32'(timeout), 0);
        chk("busy_fall", 32'(busy), 0);
      end
      if (e == 45) chk("valid_one_cycle", 32'(valid), 0);
      if (e == 100) chk("width_held", 32'(width), 15);

      // 6-bit instance: echo high 80 edges (10..89) saturates at 63
      if (e == 92) chk("valid6_early", 32'(valid6), 0);
      if (e == 93) begin
        chk("valid6_pulse", 32'(valid6), 1);
        chk("width6_sat", 32'(width6), 63);
        chk("timeout6_none", 32'(timeout6), 0);
      end

      // Cadence: second trigger exactly 200 cycles after the first
      if (e == 200) begin
        chk("trig2_not_yet", 32'(trig), 0);
        chk("win1_valids", 32'(v_cnt), 1);
        chk("win1_timeouts", 32'(t_cnt), 0);
        v_cnt = 0;
        t_cnt = 0;
      end
      if (e == 201) chk("trig2_rise", 32'(trig), 1);

      // No echo: WAIT_RISE entered at 206, timeout at 306
      if (e == 305) chk("timeout_early", 32'(timeout), 0);
      if (e == 306) begin
        chk("timeout_pulse", 32'(timeout), 1);
        chk("width_ones", 32'(width), 255);
        chk("valid_on_timeout", 32'(valid), 0);
        chk("busy_timeout", 32'(busy), 0);
      end
      if (e == 307) begin
        chk("timeout_one_cycle", 32'(timeout), 0);
        chk("width_ones_held", 32'(width), 255);
      end
      if (e == 400) begin
        chk("win2_valids", 32'(v_cnt), 0);
        chk("win2_timeouts", 32'(t_cnt), 1);
        v_cnt = 0;
        t_cnt = 0;
      end
      if (e == 401) chk("trig3_rise", 32'(trig), 1);

      // Echo already high before trigger 3: ignored, timeout at 506
      if (e == 506) begin
        chk("held_timeout", 32'(timeout), 1);
        chk("held_no_valid", 32'(valid), 0);
      end
      if (e == 600) begin
        chk("win3_valids", 32'(v_cnt), 0);
        chk("win3_timeouts", 32'(t_cnt), 1);
        v_cnt = 0;
        t_cnt = 0;
      end

      // Reset sampled at edge 620 during MEASURE
      if (e == 620) begin
        chk("midrst_trig", 32'(trig), 0);
        chk("midrst_width", 32'(width), 0);
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_timeout", 32'(timeout), 0);
        chk("midrst_busy", 32'(busy), 0);
      end
      if (e >= 621 && e <= 625) chk($sformatf("trig_after_rst_e%0d", e), 32'(trig), 1);
      if (e == 626) chk("trig_after_rst_fall", 32'(trig), 0);
      if (e == 720) begin
        chk("win4_valids", 32'(v_cnt), 0);
        chk("win4_timeouts", 32'(t_cnt), 0);
      end
      if (e == 726) chk("post_rst_timeout", 32'(timeout), 1);

      // Drive inputs for the next edge
      rst   = ((e + 1) == 620);
      echo  = ((e + 1) inside {[26:40], [380:519], [610:639]});
      echo6 = ((e + 1) inside {[10:89]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
